keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 181 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce.
//
// Drives one keypad row low at a time, samples the (synchronized) columns once
// per scan tick, debounces both press and release, and reports the accepted
// key as row*4 + column.
//
// Ports:
//   clk         in   sole clock, rising edge
//   rst         in   synchronous, active-low reset
//   col_in[3:0] in   keypad columns, active-low, asynchronous to clk
//   row_out[3:0] out row drive, active-low, exactly one bit low
//   key_code[3:0] out last accepted key (held across release)
//   key_valid   out  one-clock pulse on acceptance
//   key_pressed out  level, high from acceptance until release is accepted
//   dbg_state[1:0] out current FSM state (0 SCAN, 1 DEBOUNCE, 2 HOLD)
//
// Handshake: key_valid is a pure strobe with no ready; a consumer that wants
// the key must capture key_code in the cycle key_valid is high (key_code also
// stays stable until the next acceptance).
module keypad_scanner #(
    parameter int SCAN_DIV       = 1024,
    parameter int DEBOUNCE_SCANS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_pressed,
    output logic [1:0] dbg_state
);

    localparam int TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    // Match/release counters must hold DEBOUNCE_SCANS itself.
    localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HOLD     = 2'd2
    } state_t;

    logic [3:0]        sync1_q, sync1_d;
    logic [3:0]        col_s_q, col_s_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    state_t            state_q, state_d;
    logic [1:0]        r_q, r_d;
    logic [3:0]        pat_q, pat_d;
    logic [1:0]        row_q, row_d;
    logic [CNT_W-1:0]  match_q, match_d;
    logic [CNT_W-1:0]  rel_q, rel_d;
    logic [3:0]        key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic              key_pressed_q, key_pressed_d;
    logic              tick;

    // Lowest-index zero bit: several keys down in one row resolve to the
    // lowest column.
    function automatic logic [1:0] lowest_zero(input logic [3:0] p);
        if (!p[0])      return 2'd0;
        else if (!p[1]) return 2'd1;
        else if (!p[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    always_comb begin
        tick          = (tick_cnt_q == TICK_LAST);
        sync1_d       = col_in;
        col_s_d       = sync1_q;
        tick_cnt_d    = tick ? '0 : tick_cnt_q + TICK_ONE;
        state_d       = state_q;
        r_d           = r_q;
        pat_d         = pat_q;
        row_d         = row_q;
        match_d       = match_q;
        rel_d         = rel_q;
        key_code_d    = key_code_q;
        key_valid_d   = 1'b0;
        key_pressed_d = key_pressed_q;

        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (col_s_q == 4'hF) begin
                        r_d = r_q + 2'd1;
                    end else begin
                        pat_d   = col_s_q;
                        row_d   = r_q;
                        match_d = CNT_ONE;
                        // A single-sample debounce accepts on the detection tick.
                        if (CNT_ONE == CNT_DONE) begin
                            key_valid_d   = 1'b1;
                            key_code_d    = {r_q, lowest_zero(col_s_q)};
                            key_pressed_d = 1'b1;
                            rel_d         = '0;
                            state_d       = ST_HOLD;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (col_s_q == pat_q) begin
                        match_d = match_q + CNT_ONE;
                        if (match_d == CNT_DONE) begin
                            key_valid_d   = 1'b1;
                            key_code_d    = {row_q, lowest_zero(pat_q)};
                            key_pressed_d = 1'b1;
                            rel_d         = '0;
                            state_d       = ST_HOLD;
                        end
                    end else begin
                        // Any other sample (idle or a new pattern) aborts.
                        match_d = '0;
                        r_d     = r_q + 2'd1;
                        state_d = ST_SCAN;
                    end
                end
                ST_HOLD: begin
                    if (col_s_q == 4'hF) begin
                        rel_d = rel_q + CNT_ONE;
                        if (rel_d == CNT_DONE) begin
                            rel_d         = '0;
                            key_pressed_d = 1'b0;
                            r_d           = r_q + 2'd1;
                            state_d       = ST_SCAN;
                        end
                    end else begin
                        rel_d = '0;
                    end
                end
                default: begin
                    state_d = ST_SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q       <= 4'hF;
            col_s_q       <= 4'hF;
            tick_cnt_q    <= '0;
            state_q       <= ST_SCAN;
            r_q           <= 2'd0;
            pat_q         <= 4'hF;
            row_q         <= 2'd0;
            match_q       <= '0;
            rel_q         <= '0;
            key_code_q    <= 4'h0;
            key_valid_q   <= 1'b0;
            key_pressed_q <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            col_s_q       <= col_s_d;
            tick_cnt_q    <= tick_cnt_d;
            state_q       <= state_d;
            r_q           <= r_d;
            pat_q         <= pat_d;
            row_q         <= row_d;
            match_q       <= match_d;
            rel_q         <= rel_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_pressed_q <= key_pressed_d;
        end
    end

    assign row_out     = ~(4'b0001 << r_q);
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_pressed = key_pressed_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=3).
// A keypad model turns a 16-bit "keys held" mask into col_in from row_out.
// A tick-level reference model tracks sample history in queues and predicts
// row_out, key_valid, key_pressed and key_code after every clock.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DS       = 3;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_pressed;
  logic [1:0] dbg_state;

  keypad_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .col_in     (col_in),
    .row_out    (row_out),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_pressed(key_pressed),
    .dbg_state  (dbg_state)
  );

  // ---------------- keypad physics ----------------
  logic [15:0] keys = '0;

  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && keys[r*4+c]) col_in[c] = 1'b0;
  end

  // ---------------- reference model ----------------
  int         m_clk;
  int         m_row;
  logic [3:0] streak_q[$];
  logic [3:0] hold_q[$];
  bit         m_held;
  logic [3:0] m_code;
  logic       m_pressed;
  logic       m_valid;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;

  function automatic logic [3:0] keypad_view(logic [15:0] k, int row);
    logic [3:0] s = 4'hF;
    for (int c = 0; c < 4; c++) if (k[row*4+c]) s[c] = 1'b0;
    return s;
  endfunction

  function automatic int low_col(logic [3:0] s);
    for (int c = 0; c < 4; c++) if (!s[c]) return c;
    return 0;
  endfunction

  function automatic bit release_seen();
    if (hold_q.size() < DS) return 1'b0;
    for (int i = hold_q.size() - DS; i < hold_q.size(); i++)
      if (hold_q[i] != 4'hF) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] exp_row();
    logic [3:0] v = 4'hF;
    v[m_row] = 1'b0;
    return v;
  endfunction

  task automatic model_reset();
    m_clk     = 0;
    m_row     = 0;
    streak_q.delete();
    hold_q.delete();
    m_held    = 1'b0;
    m_code    = 4'h0;
    m_pressed = 1'b0;
    m_valid   = 1'b0;
  endtask

  // One scan sample of the currently driven row.
  task automatic model_tick();
    logic [3:0] s;
    s = keypad_view(keys, m_row);
    if (m_held) begin
      hold_q.push_back(s);
      if (release_seen()) begin
        m_pressed = 1'b0;
        m_held    = 1'b0;
        hold_q.delete();
        m_row     = (m_row + 1) % 4;
      end
    end else if (s == 4'hF || (streak_q.size() > 0 && s != streak_q[0])) begin
      streak_q.delete();
      m_row = (m_row + 1) % 4;
    end else begin
      streak_q.push_back(s);
      if (streak_q.size() == DS) begin
        m_valid   = 1'b1;
        m_pressed = 1'b1;
        m_held    = 1'b1;
        m_code    = 4'(m_row * 4 + low_col(s));
        streak_q.delete();
        hold_q.delete();
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    m_valid = 1'b0;
    if ((m_clk % SCAN_DIV) == SCAN_DIV - 1) model_tick();
    m_clk++;
    @(posedge clk);
    #1;
    chk("row_out", 16'(row_out), 16'(exp_row()));
    chk("key_valid", 16'(key_valid), 16'(m_valid));
    chk("key_pressed", 16'(key_pressed), 16'(m_pressed));
    chk("key_code", 16'(key_code), 16'(m_code));
    if (key_valid) pulses++;
  endtask

  task automatic run_ticks(int n);
    for (int i = 0; i < n * SCAN_DIV; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b0;
    keys = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_row_out", 16'(row_out), 16'h000E);
    chk("reset_key_code", 16'(key_code), 16'h0000);
    chk("reset_key_valid", 16'(key_valid), 16'h0000);
    chk("reset_key_pressed", 16'(key_pressed), 16'h0000);
    rst = 1'b1;
    model_reset();

    // Idle scan: 64 clocks, four clocks per row, no pulse.
    pulses = 0;
    run_ticks(16);
    chk("idle_pulses", 16'(pulses), 16'd0);
    chk("idle_row_wrap", 16'(row_out), 16'h000E);

    // Clean press of row 2 / column 1, then release.
    do_reset();
    pulses = 0;
    keys = 16'h0200;
    run_ticks(6);
    chk("press_pulses", 16'(pulses), 16'd1);
    chk("press_code", 16'(key_code), 16'h0009);
    chk("press_level", 16'(key_pressed), 16'd1);
    keys = '0;
    run_ticks(3);
    chk("release_level", 16'(key_pressed), 16'd0);
    chk("release_row", 16'(row_out), 16'h0007);
    chk("release_code_held", 16'(key_code), 16'h0009);

    // Bounce: two ticks of contact, one tick open, repeated.
    do_reset();
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      keys = 16'h0200;
      run_ticks(2);
      keys = '0;
      run_ticks(1);
    end
    chk("bounce_pulses", 16'(pulses), 16'd0);

    // Two keys in row 0: pattern change during debounce aborts.
    do_reset();
    pulses = 0;
    keys = 16'h0009;
    run_ticks(1);
    keys = 16'h0001;
    run_ticks(1);
    chk("abort_row", 16'(row_out), 16'h000D);
    keys = '0;
    run_ticks(4);
    chk("abort_pulses", 16'(pulses), 16'd0);
    keys = 16'h0009;
    run_ticks(10);
    chk("two_key_pulses", 16'(pulses), 16'd1);
    chk("two_key_code", 16'(key_code), 16'h0000);
    chk("two_key_level", 16'(key_pressed), 16'd1);
    keys = '0;
    run_ticks(4);

    // Long hold of row 3 / column 3: no auto-repeat.
    do_reset();
    pulses = 0;
    keys = 16'h8000;
    run_ticks(40);
    chk("hold_pulses", 16'(pulses), 16'd1);
    chk("hold_code", 16'(key_code), 16'h000F);
    chk("hold_level", 16'(key_pressed), 16'd1);

    // Reset mid-hold, key still down: re-detected and accepted again.
    pulses = 0;
    do_reset();
    chk("midhold_rst_row", 16'(row_out), 16'h000E);
    chk("midhold_rst_level", 16'(key_pressed), 16'd0);
    chk("midhold_rst_code", 16'(key_code), 16'h0000);
    chk("midhold_rst_valid", 16'(key_valid), 16'd0);
    run_ticks(8);
    chk("redetect_pulses", 16'(pulses), 16'd1);
    chk("redetect_code", 16'(key_code), 16'h000F);
    keys = '0;
    run_ticks(4);

    // Randomized key activity against the model.
    do_reset();
    for (int seg = 0; seg < 30; seg++) begin
      case ($urandom_range(0, 3))
        0:       keys = '0;
        1, 3:    keys = 16'(1) << $urandom_range(0, 15);
        default: keys = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      endcase
      run_ticks($urandom_range(1, 8));
    end
    keys = '0;
    run_ticks(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
